axi_transmit: RTL and testbench
===============================

Name: axi_transmit

Overview:
- Serializes one DATA_WIDTH-wide word into a sequence of BUS_WIDTH-wide packets on the packet bus. Packets go out least-significant slice first.
- It is the transmit-side counterpart of the packet-assembly path. It sits between register/DAC-side word sources and the narrow PS-side packet bus.
- A valid/ready packet handshake provides downstream backpressure. A busy flag provides upstream flow control.

Parameters:
- BUS_WIDTH, 16: width of one packet on the bus.
- DATA_WIDTH, 32: width of the word to transmit.
- NUM_PACKS (localparam), ceil(DATA_WIDTH/BUS_WIDTH), minimum 1: packets per word.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  DATA_WIDTH  word to transmit; sampled only when accepted.
- valid_data  input  1  request to send data.
- busy  output  1  high while a word is being transmitted; words are accepted only when low.
- drop  output  1  one-cycle pulse when valid_data arrives while busy; that word is discarded.
- packet  output  BUS_WIDTH  current packet.
- valid_pack  output  1  packet is valid.
- pack_rdy  input  1  downstream accepts the packet this cycle.
- last_pack  output  1  high with valid_pack on the final packet of a word.
- send_done  output  1  one-cycle pulse after the final packet handshake.

Behaviour:
- Reset, asynchronous and immediate:
  - State goes to IDLE; shift register and counter clear.
  - busy, drop, packet, valid_pack, last_pack and send_done are all 0.
- Reset mid-transfer discards the partial word. No send_done is issued for it.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- FSM has two states: IDLE and SEND.
- IDLE:
  - busy=0, valid_pack=0.
  - If valid_data=1: latch data, zero-extended to NUM_PACKS*BUS_WIDTH, into the shift register. Set pack_cnt=0 and go to SEND.
- SEND:
  - busy=1, valid_pack=1.
  - packet = shreg[BUS_WIDTH-1:0].
  - last_pack = (pack_cnt == NUM_PACKS-1).
- Handshake (valid_pack && pack_rdy):
  - Shift shreg right by BUS_WIDTH and increment pack_cnt.
  - If last_pack: go to IDLE next cycle and pulse send_done in that cycle.
- While pack_rdy=0: packet, valid_pack and last_pack hold stable. valid_pack never deasserts before the handshake.
- Latency with valid_data at cycle t and pack_rdy tied high:
  - Packets at t+1 .. t+NUM_PACKS.
  - busy high over t+1 .. t+NUM_PACKS.
  - send_done at t+NUM_PACKS+1.
  - The next word can be accepted at t+NUM_PACKS+1, giving one bubble cycle between words.
- Simultaneous events:
  - valid_data in the same cycle as the final handshake is dropped, because busy is still 1.
  - valid_data in the send_done cycle is accepted.
- Width rules:
  - BUS_WIDTH >= DATA_WIDTH: exactly one packet; data sits in the LSBs and the upper bits are 0.
  - DATA_WIDTH not a multiple of BUS_WIDTH: the upper bits of the final packet are 0.
- pack_cnt is $clog2(NUM_PACKS+1) bits wide. It never wraps within a word and clears on acceptance.
- drop is a single-cycle pulse for each cycle in which valid_data && busy. The in-flight word is unaffected.

Test Plan:
- BUS=16, DATA=32, pack_rdy=1, data=0xDEADBEEF at t -> packet 0xBEEF at t+1 and 0xDEAD at t+2 with last_pack=1; send_done at t+3; busy=0 at t+3.
- Same config with pack_rdy=0 for t+1..t+3 -> 0xBEEF held stable with valid_pack=1 through t+4; 0xDEAD at t+5; send_done at t+6.
- BUS=16, DATA=40, data=0xAB12345678 -> packets 0x5678, 0x1234, 0x00AB; last_pack only on the third.
- BUS=64, DATA=32, data=0x0BADF00D -> single packet 0x000000000BADF00D with last_pack=1; send_done one cycle later.
- valid_data=0x11111111 during SEND of 0x22222222 -> drop pulses one cycle; packets are still 0x2222, 0x2222; a second word issued in the send_done cycle is accepted.
- rst asserted after the first packet handshake -> all outputs 0 immediately; no send_done; next word 0xCAFEF00D transmits correctly from packet 0xF00D.

Source files
------------

// File: rtl/axi_transmit.sv
// Word-to-packet serializer: splits a DATA_WIDTH word into BUS_WIDTH packets,
// least-significant slice first, with valid/ready backpressure and busy/drop upstream.
module axi_transmit #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid_data,
  output logic                  busy,
  output logic                  drop,
  output logic [BUS_WIDTH-1:0]  packet,
  output logic                  valid_pack,
  input  logic                  pack_rdy,
  output logic                  last_pack,
  output logic                  send_done
);

  localparam int RAW_PACKS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int NUM_PACKS = (RAW_PACKS < 1) ? 1 : RAW_PACKS;
  localparam int SHW       = NUM_PACKS * BUS_WIDTH;
  localparam int CW        = $clog2(NUM_PACKS + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]   packCnt_q, packCnt_d;
  logic            drop_q, drop_d;
  logic            sendDone_q, sendDone_d;
  logic            isSend;
  logic            isLast;

  assign isSend = (state_q == SEND);
  assign isLast = isSend && (packCnt_q == CW'(NUM_PACKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      packCnt_q  <= '0;
      drop_q     <= 1'b0;
      sendDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      packCnt_q  <= packCnt_d;
      drop_q     <= drop_d;
      sendDone_q <= sendDone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    packCnt_d  = packCnt_q;
    drop_d     = valid_data && isSend;
    sendDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_data) begin
          // Zero-extend so any slack in the final packet reads as zero.
          shreg_d                   = '0;
          shreg_d[DATA_WIDTH-1:0]   = data;
          packCnt_d                 = '0;
          state_d                   = SEND;
        end
      end
      SEND: begin
        if (pack_rdy) begin
          shreg_d   = shreg_q >> BUS_WIDTH;
          packCnt_d = packCnt_q + CW'(1);
          if (isLast) begin
            state_d    = IDLE;
            sendDone_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = isSend;
  assign valid_pack = isSend;
  assign packet     = isSend ? shreg_q[BUS_WIDTH-1:0] : '0;
  assign last_pack  = isLast;
  assign drop       = drop_q;
  assign send_done  = sendDone_q;

endmodule

// File: tb/tb_axi_transmit.sv
// Bench for axi_transmit: a queue-of-packets reference model drives randomized and
// directed traffic on a 16/32 instance; 16/40 and 64/32 instances cover width rules.
module tb_axi_transmit;

  logic clk;
  logic rst;

  // 16/32 instance, model-checked
  logic [31:0] dataM;
  logic        validDataM, packRdyM;
  logic        busyM, dropM, validPackM, lastPackM, sendDoneM;
  logic [15:0] packetM;

  // 16/40 instance
  logic [39:0] data40;
  logic        validData40, packRdy40;
  logic        busy40, drop40, validPack40, lastPack40, sendDone40;
  logic [15:0] packet40;

  // 64/32 instance
  logic [31:0] data64;
  logic        validData64, packRdy64;
  logic        busy64, drop64, validPack64, lastPack64, sendDone64;
  logic [63:0] packet64;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] pktQ[$];
  logic        expDrop;
  logic        expDone;

  axi_transmit #(.BUS_WIDTH(16), .DATA_WIDTH(32)) dutMain (
    .clk(clk), .rst(rst), .data(dataM), .valid_data(validDataM),
    .busy(busyM), .drop(dropM), .packet(packetM), .valid_pack(validPackM),
    .pack_rdy(packRdyM), .last_pack(lastPackM), .send_done(sendDoneM)
  );

  axi_transmit #(.BUS_WIDTH(16), .DATA_WIDTH(40)) dut40 (
    .clk(clk), .rst(rst), .data(data40), .valid_data(validData40),
    .busy(busy40), .drop(drop40), .packet(packet40), .valid_pack(validPack40),
    .pack_rdy(packRdy40), .last_pack(lastPack40), .send_done(sendDone40)
  );

  axi_transmit #(.BUS_WIDTH(64), .DATA_WIDTH(32)) dut64 (
    .clk(clk), .rst(rst), .data(data64), .valid_data(validData64),
    .busy(busy64), .drop(drop64), .packet(packet64), .valid_pack(validPack64),
    .pack_rdy(packRdy64), .last_pack(lastPack64), .send_done(sendDone64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs follow directly from what is still waiting to go out.
  task automatic checkMain();
    logic [15:0] expPkt;
    expPkt = (pktQ.size() > 0) ? pktQ[0] : 16'h0;
    checkOutput("busy",      {63'b0, busyM},      {63'b0, pktQ.size() > 0});
    checkOutput("validPack", {63'b0, validPackM}, {63'b0, pktQ.size() > 0});
    checkOutput("packet",    {48'b0, packetM},    {48'b0, expPkt});
    checkOutput("lastPack",  {63'b0, lastPackM},  {63'b0, pktQ.size() == 1});
    checkOutput("drop",      {63'b0, dropM},      {63'b0, expDrop});
    checkOutput("sendDone",  {63'b0, sendDoneM},  {63'b0, expDone});
  endtask

  task automatic modelAdvance(input logic vd, input logic [31:0] d, input logic rdy);
    bit wasBusy;
    wasBusy = (pktQ.size() > 0);
    expDrop = vd && wasBusy;
    expDone = 1'b0;
    if (wasBusy) begin
      if (rdy) begin
        void'(pktQ.pop_front());
        if (pktQ.size() == 0) expDone = 1'b1;
      end
    end else if (vd) begin
      pktQ.push_back(d[15:0]);
      pktQ.push_back(d[31:16]);
    end
  endtask

  task automatic applyStimulus(input logic vd, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    checkMain();
    validDataM = vd;
    dataM      = d;
    packRdyM   = rdy;
    modelAdvance(vd, d, rdy);
  endtask

  task automatic resetMid();
    @(negedge clk);
    checkMain();
    validDataM = 1'b0;
    packRdyM   = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rstBusy",      {63'b0, busyM},      64'h0);
    checkOutput("rstValidPack", {63'b0, validPackM}, 64'h0);
    checkOutput("rstPacket",    {48'b0, packetM},    64'h0);
    checkOutput("rstLastPack",  {63'b0, lastPackM},  64'h0);
    checkOutput("rstDrop",      {63'b0, dropM},      64'h0);
    checkOutput("rstSendDone",  {63'b0, sendDoneM},  64'h0);
    #1;
    rst = 1'b0;
    pktQ.delete();
    expDrop = 1'b0;
    expDone = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dataM = '0;  validDataM = 1'b0;  packRdyM = 1'b0;
    data40 = '0; validData40 = 1'b0; packRdy40 = 1'b1;
    data64 = '0; validData64 = 1'b0; packRdy64 = 1'b1;
    expDrop = 1'b0;
    expDone = 1'b0;
    #2;
    checkOutput("resetBusy",   {63'b0, busyM},      64'h0);
    checkOutput("resetValid",  {63'b0, validPackM}, 64'h0);
    checkOutput("resetPacket", {48'b0, packetM},    64'h0);
    checkOutput("resetBusy40", {63'b0, busy40},     64'h0);
    #10;
    rst = 1'b0;

    // Straight two-packet transfer.
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("beefConst", {48'b0, packetM}, 64'hBEEF);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("deadConst", {48'b0, packetM}, 64'hDEAD);
    checkOutput("deadLast",  {63'b0, lastPackM}, 64'h1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("doneConst", {63'b0, sendDoneM}, 64'h1);

    // Backpressure holds the first packet for three extra cycles.
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("heldPacket", {48'b0, packetM}, 64'hBEEF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Word arriving mid-send is dropped; word in the send_done cycle is taken.
    applyStimulus(1'b1, 32'h22222222, 1'b1);
    applyStimulus(1'b1, 32'h11111111, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("dropPulse", {63'b0, dropM}, 64'h1);
    applyStimulus(1'b1, 32'h33333333, 1'b1);
    checkOutput("doneCycle", {63'b0, sendDoneM}, 64'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Reset after the first handshake, then a clean word.
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    resetMid();
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("cafeLo", {48'b0, packetM}, 64'hF00D);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) resetMid();
      else applyStimulus($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    checkMain();

    // Three-packet word with a partially filled top packet.
    @(negedge clk);
    validData40 = 1'b1;
    data40 = 40'hAB12345678;
    @(negedge clk);
    validData40 = 1'b0;
    checkOutput("w40p0",    {48'b0, packet40},   64'h5678);
    checkOutput("w40last0", {63'b0, lastPack40}, 64'h0);
    @(negedge clk);
    checkOutput("w40p1",    {48'b0, packet40},   64'h1234);
    checkOutput("w40last1", {63'b0, lastPack40}, 64'h0);
    @(negedge clk);
    checkOutput("w40p2",    {48'b0, packet40},   64'h00AB);
    checkOutput("w40last2", {63'b0, lastPack40}, 64'h1);
    @(negedge clk);
    checkOutput("w40done",  {63'b0, sendDone40}, 64'h1);
    checkOutput("w40busy",  {63'b0, busy40},     64'h0);

    // Bus wider than the word: single zero-extended packet.
    validData64 = 1'b1;
    data64 = 32'h0BADF00D;
    @(negedge clk);
    validData64 = 1'b0;
    checkOutput("w64packet", packet64,             64'h000000000BADF00D);
    checkOutput("w64last",   {63'b0, lastPack64},  64'h1);
    checkOutput("w64valid",  {63'b0, validPack64}, 64'h1);
    @(negedge clk);
    checkOutput("w64done",   {63'b0, sendDone64},  64'h1);
    checkOutput("w64busy",   {63'b0, busy64},      64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
